// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Types and constants shared by the multi-cycle RV32I control unit and the
// DataPath: FSM state encoding, base opcodes, ALU / branch-compare codes and
// register-file write-data source selects.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4
    } state_e;

    // Base opcodes (instrCode[6:0])
    localparam logic [6:0] OP_TYPE_R     = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I     = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L     = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S     = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B     = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JALR  = 7'b1100111;

    // ALU operation codes: {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Branch compare selects, carried on aluControl[2:0] (= funct3)
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Register-file write-data source selects
    localparam logic [2:0] RFWD_ALU    = 3'd0;
    localparam logic [2:0] RFWD_MEM    = 3'd1;
    localparam logic [2:0] RFWD_IMM    = 3'd2;
    localparam logic [2:0] RFWD_PC_IMM = 3'd3;
    localparam logic [2:0] RFWD_PC_4   = 3'd4;

    // Opcodes whose instruction writes a destination register.
    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode == OP_TYPE_R)   || (opcode == OP_TYPE_I)     ||
               (opcode == OP_TYPE_L)   || (opcode == OP_TYPE_LUI)   ||
               (opcode == OP_TYPE_AUIPC) || (opcode == OP_TYPE_JAL) ||
               (opcode == OP_TYPE_JALR);
    endfunction

endpackage

// File: rtl/rv32i_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// rv32i_ctrl_decoder
// Purely combinational decode of the current instruction into the static
// DataPath controls (held for the whole instruction) plus the class flags the
// sequencing FSM needs.
// Ports:
//   instr_i          in  32  current instruction word
//   alu_control_o    out 4   ALU op / branch compare select on [2:0]
//   alu_src_sel_o    out 1   0=RS2, 1=immExt
//   rfwd_src_sel_o   out 3   register-file write-data source
//   branch_o         out 1   B-type
//   jal_o            out 1   JAL or JALR
//   jalr_o           out 1   JALR
//   is_load_o        out 1   load: needs MEM then WB
//   is_store_o       out 1   store: finishes in MEM
//   rf_write_o       out 1   instruction writes rd
// ---------------------------------------------------------------------------
module rv32i_ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_control_o,
    output logic        alu_src_sel_o,
    output logic [2:0]  rfwd_src_sel_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        rf_write_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7_5 = instr_i[30];

    // Register indices and immediates are consumed by the DataPath only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    assign is_load_o  = (opcode == OP_TYPE_L);
    assign is_store_o = (opcode == OP_TYPE_S);
    assign rf_write_o = writes_rd(opcode);

    always_comb begin
        alu_control_o  = ALU_ADD;
        alu_src_sel_o  = 1'b0;
        rfwd_src_sel_o = RFWD_ALU;
        branch_o       = 1'b0;
        jal_o          = 1'b0;
        jalr_o         = 1'b0;
        case (opcode)
            OP_TYPE_R: alu_control_o = {funct7_5, funct3};
            OP_TYPE_I: begin
                // funct7[5] only distinguishes SRAI from SRLI; for every other
                // I-type op those bits are immediate and must be ignored.
                alu_control_o = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                alu_src_sel_o = 1'b1;
            end
            OP_TYPE_L: begin
                alu_src_sel_o  = 1'b1;
                rfwd_src_sel_o = RFWD_MEM;
            end
            OP_TYPE_S:     alu_src_sel_o = 1'b1;
            OP_TYPE_B: begin
                alu_control_o = {1'b0, funct3};
                branch_o      = 1'b1;
            end
            OP_TYPE_LUI:   rfwd_src_sel_o = RFWD_IMM;
            OP_TYPE_AUIPC: rfwd_src_sel_o = RFWD_PC_IMM;
            OP_TYPE_JAL: begin
                jal_o          = 1'b1;
                rfwd_src_sel_o = RFWD_PC_4;
            end
            OP_TYPE_JALR: begin
                jal_o          = 1'b1;
                jalr_o         = 1'b1;
                alu_src_sel_o  = 1'b1;
                rfwd_src_sel_o = RFWD_PC_4;
            end
            default: ;  // unknown opcode decodes as a NOP
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// Sequences the multi-cycle RV32I DataPath: FETCH -> DECODE -> EXECUTE, then
// MEM and/or WB depending on the instruction class, back to FETCH. Write
// enables and PC load are gated by state; all other controls come straight
// from the decoder and are held for the whole instruction.
// Ports:
//   clk            in  1   system clock, rising edge
//   reset_n        in  1   asynchronous active-low reset
//   instrCode      in  32  current instruction (stable while PCEn=0)
//   regFileWe      out 1   register-file write enable (WB only)
//   aluControl     out 4   ALU op; [2:0] also branch compare select
//   aluSrcMuxSel   out 1   0=RS2, 1=immExt
//   RFWDSrcMuxSel  out 3   0=ALU,1=mem,2=imm,3=PC+imm,4=PC+4
//   branch         out 1   B-type qualifier
//   jal            out 1   JAL or JALR
//   jalr           out 1   JALR
//   dataWe         out 1   data-memory write strobe (store MEM only)
//   PCEn           out 1   PC load; final cycle of the instruction
//   instrDone      out 1   copy of PCEn
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instrCode,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        dataWe,
    output logic        PCEn,
    output logic        instrDone
);

    state_e state_q, state_d;
    logic   is_load, is_store, rf_write;

    rv32i_ctrl_decoder u_decoder (
        .instr_i        (instrCode),
        .alu_control_o  (aluControl),
        .alu_src_sel_o  (aluSrcMuxSel),
        .rfwd_src_sel_o (RFWDSrcMuxSel),
        .branch_o       (branch),
        .jal_o          (jal),
        .jalr_o         (jalr),
        .is_load_o      (is_load),
        .is_store_o     (is_store),
        .rf_write_o     (rf_write)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = (is_load || is_store) ? MEM : WB;
            MEM:     state_d = is_load ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // State-gated outputs. Every instruction except a store ends in WB, so
    // PCEn there is unconditional (unknown opcodes advance PC+4 as a NOP).
    always_comb begin
        regFileWe = 1'b0;
        dataWe    = 1'b0;
        PCEn      = 1'b0;
        case (state_q)
            MEM: begin
                dataWe = is_store;
                PCEn   = is_store;
            end
            WB: begin
                regFileWe = rf_write;
                PCEn      = 1'b1;
            end
            default: ;
        endcase
    end

    assign instrDone = PCEn;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Drives directed and random instructions one at a time and compares every
// output in every cycle with a per-instruction reference built from the
// instruction-class rules (latency, which strobes fire in the last cycle,
// and the static control values).
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instrCode = 32'h0000_0013;
    logic        regFileWe, aluSrcMuxSel, branch, jal, jalr, dataWe, PCEn, instrDone;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instrCode     (instrCode),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .dataWe        (dataWe),
        .PCEn          (PCEn),
        .instrDone     (instrDone)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what an instruction should do, derived from its class.
    typedef struct {
        int         lat;
        bit         rf_we;
        bit         data_we;
        logic [3:0] aluc;
        bit         src;
        logic [2:0] rfwd;
        bit         br;
        bit         j;
        bit         jr;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e = '{lat: 4, rf_we: 0, data_we: 0, aluc: 4'd0, src: 0, rfwd: 3'd0, br: 0, j: 0, jr: 0};
        case (ins[6:0])
            7'h33: begin e.rf_we = 1; e.aluc = {ins[30], f3}; end
            7'h13: begin e.rf_we = 1; e.src = 1; e.aluc = {(f3 == 3'd5) ? ins[30] : 1'b0, f3}; end
            7'h03: begin e.lat = 5; e.rf_we = 1; e.src = 1; e.rfwd = 3'd1; end
            7'h23: begin e.data_we = 1; e.src = 1; end
            7'h63: begin e.br = 1; e.aluc = {1'b0, f3}; end
            7'h37: begin e.rf_we = 1; e.rfwd = 3'd2; end
            7'h17: begin e.rf_we = 1; e.rfwd = 3'd3; end
            7'h6F: begin e.rf_we = 1; e.j = 1; e.rfwd = 3'd4; end
            7'h67: begin e.rf_we = 1; e.j = 1; e.jr = 1; e.src = 1; e.rfwd = 3'd4; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_static(input string name, input int c, input exp_t e);
        check_eq($sformatf("%s c%0d aluControl", name, c), 32'(aluControl), 32'(e.aluc));
        check_eq($sformatf("%s c%0d aluSrcMuxSel", name, c), 32'(aluSrcMuxSel), 32'(e.src));
        check_eq($sformatf("%s c%0d RFWDSrcMuxSel", name, c), 32'(RFWDSrcMuxSel), 32'(e.rfwd));
        check_eq($sformatf("%s c%0d branch", name, c), 32'(branch), 32'(e.br));
        check_eq($sformatf("%s c%0d jal", name, c), 32'(jal), 32'(e.j));
        check_eq($sformatf("%s c%0d jalr", name, c), 32'(jalr), 32'(e.jr));
    endtask

    task automatic check_strobes(input string name, input int c, input bit rf, input bit dw, input bit pc);
        check_eq($sformatf("%s c%0d regFileWe", name, c), 32'(regFileWe), 32'(rf));
        check_eq($sformatf("%s c%0d dataWe", name, c), 32'(dataWe), 32'(dw));
        check_eq($sformatf("%s c%0d PCEn", name, c), 32'(PCEn), 32'(pc));
        check_eq($sformatf("%s c%0d instrDone", name, c), 32'(instrDone), 32'(pc));
    endtask

    // Called just after a rising edge with the FSM expected in FETCH.
    task automatic run_instr(input logic [31:0] ins, input string name);
        exp_t e;
        bit   fin;
        e = model(ins);
        instrCode = ins;
        for (int c = 1; c <= e.lat; c++) begin
            @(negedge clk);
            fin = (c == e.lat);
            check_strobes(name, c, fin && e.rf_we, fin && e.data_we, fin);
            check_static(name, c, e);
            @(posedge clk);
            #1;
        end
        $display("instr %-8s %08h lat=%0d rfwe=%0d dwe=%0d", name, ins, e.lat, e.rf_we, e.data_we);
    endtask

    // Store interrupted by reset during EXECUTE: nothing may be written.
    task automatic run_abort(input logic [31:0] ins);
        instrCode = ins;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_strobes("abort", c, 0, 0, 0);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #1 reset_n = 1'b0;
        #1 check_strobes("abort_rst", 3, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            check_strobes("abort_hold", 4, 0, 0, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        $display("instr abort    %08h reset in EXECUTE", ins);
    endtask

    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    logic [6:0] bad_ops[4] = '{7'h7F, 7'h00, 7'h0B, 7'h5B};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;

        // Reset held for three cycles: strobes stay low.
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_strobes("reset", c, 0, 0, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;

        run_instr(32'h002081B3, "add");
        run_instr(32'h0080A283, "lw");
        run_instr(32'h0020A223, "sw");
        run_instr(32'h00000463, "beq");
        run_instr(32'h000100E7, "jalr");
        run_instr(32'h4020D093, "srai");
        run_instr(32'h40000033, "sub");
        run_abort(32'h0020A223);
        run_instr(32'h0000007F, "nop7f");

        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h7F) op = bad_ops[$urandom_range(0, 3)];
            run_instr({r[31:7], op}, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
